serial_frame_capture: RTL and testbench

SERIAL_FRAME_CAPTURE -- requirements
Module: serial_frame_capture

---
 rtl/serial_frame_capture.sv | 173 +++++++++++++++++
 tb/tb_serial_frame_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_capture.sv
// Captures MSB-first serial words (sampled on rising I_SCLK) into frames and hands them out over a valid/ready port.
// Define SYNC_INPUT_EN to pass I_SCLK/I_SDATA through two-flop synchronizers (+2 cycles latency).
`timescale 1ns/1ps
module serial_frame_capture (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_START,
    input  logic [5:0]  I_BIT_COUNT,
    input  logic [15:0] I_WORD_COUNT,
    input  logic        I_SCLK,
    input  logic        I_SDATA,
    output logic [31:0] O_DATA,
    output logic        O_VALID,
    input  logic        I_READY,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_OVERRUN
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic sclk_s;
    logic sdata_s;

`ifdef SYNC_INPUT_EN
    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] sdata_sync_q, sdata_sync_d;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[0], I_SCLK};
        sdata_sync_d = {sdata_sync_q[0], I_SDATA};
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            sclk_sync_q  <= 2'b00;
            sdata_sync_q <= 2'b00;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
        end
    end

    assign sclk_s  = sclk_sync_q[1];
    assign sdata_s = sdata_sync_q[1];
`else
    assign sclk_s  = I_SCLK;
    assign sdata_s = I_SDATA;
`endif

    logic [1:0]  state_q, state_d;
    logic        start_q, start_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic [5:0]  bit_n_q, bit_n_d;
    logic [15:0] word_n_q, word_n_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    // Never holds more than 31 bits: the 32nd bit always completes the word.
    logic [30:0] shift_q, shift_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;

    logic        sample;
    logic        start_rise;
    logic [31:0] shifted;
    logic [5:0]  bit_n_eff;

    assign sample     = sclk_s & ~sclk_prev_q;
    assign start_rise = I_START & ~start_q;
    assign shifted    = {shift_q, sdata_s};
    assign bit_n_eff  = ((I_BIT_COUNT == 6'd0) || (I_BIT_COUNT > 6'd32)) ? 6'd32 : I_BIT_COUNT;

    always_comb begin
        state_d     = state_q;
        start_d     = I_START;
        sclk_prev_d = sclk_s;
        bit_n_d     = bit_n_q;
        word_n_d    = word_n_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        // Acceptance is honoured in every state so FLUSH can drain the last word.
        if (valid_q && I_READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_SHIFT;
                    bit_n_d    = bit_n_eff;
                    word_n_d   = I_WORD_COUNT;
                    bit_cnt_d  = 6'd0;
                    word_cnt_d = 16'd0;
                    shift_d    = 31'd0;
                    overrun_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sample) begin
                    if (bit_cnt_q + 6'd1 == bit_n_q) begin
                        bit_cnt_d  = 6'd0;
                        shift_d    = 31'd0;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (!valid_q || I_READY) begin
                            data_d  = shifted;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        shift_d   = shifted[30:0];
                    end
                end
                if (!I_START || ((word_n_q != 16'd0) && (word_cnt_d == word_n_q))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            sclk_prev_q <= 1'b0;
            bit_n_q     <= 6'd0;
            word_n_q    <= 16'd0;
            bit_cnt_q   <= 6'd0;
            word_cnt_q  <= 16'd0;
            shift_q     <= 31'd0;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            sclk_prev_q <= sclk_prev_d;
            bit_n_q     <= bit_n_d;
            word_n_q    <= word_n_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign O_DATA    = data_q;
    assign O_VALID   = valid_q;
    assign O_BUSY    = (state_q != ST_IDLE);
    assign O_DONE    = (state_q == ST_DONE);
    assign O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_serial_frame_capture.sv
// Bench for serial_frame_capture: frame table, hand-written corner sequences and random frames
// checked against a word-level expectation queue.
`timescale 1ns/1ps
module tb_serial_frame_capture;

`ifdef SYNC_INPUT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        I_CLK;
    logic        I_RST;
    logic        I_START;
    logic [5:0]  I_BIT_COUNT;
    logic [15:0] I_WORD_COUNT;
    logic        I_SCLK;
    logic        I_SDATA;
    logic [31:0] O_DATA;
    logic        O_VALID;
    logic        I_READY;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_OVERRUN;

    serial_frame_capture dut (
        .I_CLK        (I_CLK),
        .I_RST        (I_RST),
        .I_START      (I_START),
        .I_BIT_COUNT  (I_BIT_COUNT),
        .I_WORD_COUNT (I_WORD_COUNT),
        .I_SCLK       (I_SCLK),
        .I_SDATA      (I_SDATA),
        .O_DATA       (O_DATA),
        .O_VALID      (O_VALID),
        .I_READY      (I_READY),
        .O_BUSY       (O_BUSY),
        .O_DONE       (O_DONE),
        .O_OVERRUN    (O_OVERRUN)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [5:0]       bc;
        logic [15:0]      wc;
        int               partial;
        int               nw;
        logic [2:0][31:0] w;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;
    int          done_cnt;
    int          gap_max;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // One clock; word hand-offs and DONE pulses are observed on the falling edge.
    task automatic tick();
        logic [31:0] w;
        @(negedge I_CLK);
        if (!I_RST) begin
            if (O_VALID && I_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_extra actual=%h required=no_word", O_DATA);
                end else begin
                    w = exp_q.pop_front();
                    chk("accept_data", O_DATA, w);
                end
            end
            if (O_DONE) done_cnt++;
        end
        @(posedge I_CLK);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic last, input logic [31:0] expw, input int stall);
        I_SDATA = b;
        I_SCLK  = 1'b1;
        tick();
        I_SCLK  = 1'b0;
        if (last) begin
            for (int i = 1; i <= LAT; i++) begin
                if (i > 1) tick();
                chk1("valid_latency", O_VALID, (i == LAT));
                if (i == LAT) chk("word_data", O_DATA, expw);
            end
            if (stall > 0) begin
                I_READY = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    chk1("hold_valid", O_VALID, 1'b1);
                    chk("hold_data", O_DATA, expw);
                end
                I_READY = 1'b1;
            end
        end
        tick();
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
    endtask

    task automatic send_word(input logic [31:0] val, input int n, input logic do_chk, input int stall);
        if (do_chk) exp_q.push_back(val);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(val[i], do_chk && (i == 0), val, stall);
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 300 && done_cnt == 0; t++) tick();
        repeat (3) tick();
    endtask

    task automatic run_frame(input logic [5:0] bc, input logic [15:0] wc, input int nw,
                             input logic [2:0][31:0] w, input int partial, input int stallmax);
        int eff;
        eff = ((bc == 6'd0) || (bc > 6'd32)) ? 32 : int'(bc);
        done_cnt     = 0;
        I_BIT_COUNT  = bc;
        I_WORD_COUNT = wc;
        I_START      = 1'b1;
        tick();
        chk1("armed_busy", O_BUSY, 1'b1);
        chk1("armed_overrun", O_OVERRUN, 1'b0);
        for (int k = 0; k < nw; k++) begin
            send_word(w[k], eff, 1'b1, (stallmax > 0) ? $urandom_range(stallmax, 0) : 0);
        end
        for (int p = 0; p < partial; p++) send_bit(1'($urandom()), 1'b0, 32'd0, 0);
        if (wc == 16'd0) I_START = 1'b0;
        wait_done();
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk1("busy_after", O_BUSY, 1'b0);
        chk("pending_words", 32'(exp_q.size()), 32'd0);
        chk1("overrun_clear", O_OVERRUN, 1'b0);
        if (wc != 16'd0) begin
            repeat (4) tick();
            chk1("no_rearm", O_BUSY, 1'b0);
        end
        I_START = 1'b0;
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0][31:0] rw;
        logic [31:0]      mask;
        logic [5:0]       rbc;
        logic [15:0]      rwc;
        int               eff, rnw, rpart;

        checks = 0; errors = 0; done_cnt = 0; gap_max = 0;
        I_RST = 1'b1; I_START = 1'b0; I_BIT_COUNT = 6'd0; I_WORD_COUNT = 16'd0;
        I_SCLK = 1'b0; I_SDATA = 1'b0; I_READY = 1'b1;

        // Frame table: inputs (bit count, word count, trailing partial bits) and the words expected out.
        vecs[0] = '{bc: 6'd4,  wc: 16'd2, partial: 0, nw: 2, w: {32'h0, 32'h7, 32'hA}};
        vecs[1] = '{bc: 6'd0,  wc: 16'd1, partial: 0, nw: 1, w: {32'h0, 32'h0, 32'hAAAAAAAA}};
        vecs[2] = '{bc: 6'd40, wc: 16'd1, partial: 0, nw: 1, w: {32'h0, 32'h0, 32'h12345678}};
        vecs[3] = '{bc: 6'd1,  wc: 16'd3, partial: 0, nw: 3, w: {32'h1, 32'h0, 32'h1}};
        vecs[4] = '{bc: 6'd8,  wc: 16'd0, partial: 5, nw: 1, w: {32'h0, 32'h0, 32'h5A}};
        vecs[5] = '{bc: 6'd8,  wc: 16'd0, partial: 5, nw: 0, w: {32'h0, 32'h0, 32'h0}};
        vecs[6] = '{bc: 6'd32, wc: 16'd2, partial: 0, nw: 2, w: {32'h0, 32'h0F0F1234, 32'hDEADBEEF}};
        vecs[7] = '{bc: 6'd63, wc: 16'd1, partial: 0, nw: 1, w: {32'h0, 32'h0, 32'h80000001}};
        vecs[8] = '{bc: 6'd12, wc: 16'd2, partial: 0, nw: 2, w: {32'h0, 32'h801, 32'hFFF}};

        repeat (3) tick();
        chk("reset_data", O_DATA, 32'd0);
        chk1("reset_valid", O_VALID, 1'b0);
        chk1("reset_busy", O_BUSY, 1'b0);
        chk1("reset_done", O_DONE, 1'b0);
        chk1("reset_overrun", O_OVERRUN, 1'b0);
        I_RST = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].bc, vecs[v].wc, vecs[v].nw, vecs[v].w, vecs[v].partial, 0);
        end

        // Reset mid-frame with a word still pending: everything clears at once, no DONE.
        done_cnt = 0;
        I_READY = 1'b0; I_BIT_COUNT = 6'd16; I_WORD_COUNT = 16'd2; I_START = 1'b1;
        tick();
        send_word(32'hBEEF, 16, 1'b0, 0);
        repeat (LAT) tick();
        chk1("pre_reset_valid", O_VALID, 1'b1);
        chk("pre_reset_data", O_DATA, 32'hBEEF);
        for (int p = 0; p < 7; p++) send_bit(1'($urandom()), 1'b0, 32'd0, 0);
        I_RST = 1'b1; I_START = 1'b0;
        #2;
        chk("rst_async_data", O_DATA, 32'd0);
        chk1("rst_async_valid", O_VALID, 1'b0);
        chk1("rst_async_busy", O_BUSY, 1'b0);
        repeat (2) tick();
        chk1("rst_done", O_DONE, 1'b0);
        chk1("rst_overrun", O_OVERRUN, 1'b0);
        I_RST = 1'b0; I_READY = 1'b1;
        tick();
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        run_frame(6'd16, 16'd1, 1, {32'h0, 32'h0, 32'h1234}, 0, 0);

        // Consumer stalled for the whole frame: first word held, later two dropped, DONE waits for READY.
        done_cnt = 0;
        I_READY = 1'b0; I_BIT_COUNT = 6'd8; I_WORD_COUNT = 16'd3; I_START = 1'b1;
        tick();
        send_word(32'hA5, 8, 1'b0, 0);
        repeat (LAT) tick();
        chk1("ovr_first_valid", O_VALID, 1'b1);
        chk1("ovr_not_yet", O_OVERRUN, 1'b0);
        send_word(32'h3C, 8, 1'b0, 0);
        send_word(32'hFF, 8, 1'b0, 0);
        repeat (LAT + 4) tick();
        chk("ovr_held_data", O_DATA, 32'hA5);
        chk1("ovr_held_valid", O_VALID, 1'b1);
        chk1("ovr_flag", O_OVERRUN, 1'b1);
        chk1("ovr_busy", O_BUSY, 1'b1);
        chk("ovr_no_done_yet", 32'(done_cnt), 32'd0);
        exp_q.push_back(32'hA5);
        I_READY = 1'b1;
        wait_done();
        chk("ovr_done_pulses", 32'(done_cnt), 32'd1);
        chk1("ovr_sticky", O_OVERRUN, 1'b1);
        chk("ovr_pending", 32'(exp_q.size()), 32'd0);
        chk1("ovr_busy_after", O_BUSY, 1'b0);
        I_START = 1'b0;
        tick();

        // Random frames with random gaps and consumer stalls between words.
        gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            rbc  = 6'($urandom_range(63, 0));
            rwc  = 16'($urandom_range(3, 0));
            eff  = ((rbc == 6'd0) || (rbc > 6'd32)) ? 32 : int'(rbc);
            mask = (eff == 32) ? 32'hFFFFFFFF : ((32'd1 << eff) - 32'd1);
            if (rwc == 16'd0) begin
                rnw   = $urandom_range(3, 0);
                rpart = $urandom_range(eff - 1, 0);
            end else begin
                rnw   = int'(rwc);
                rpart = 0;
            end
            for (int k = 0; k < 3; k++) rw[k] = $urandom() & mask;
            run_frame(rbc, rwc, rnw, rw, rpart, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
